// File: rtl/band_mixer_if.sv
// Band mixer bus: band sample lanes, gain programming port and mixed output.
interface band_mixer_if #(
    parameter int NUM_BANDS  = 16,
    parameter int GAIN_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_BANDS)
);
    logic [NUM_BANDS-1:0][15:0] band_data;
    logic                       band_valid;
    logic                       gain_we;
    logic [IDX_WIDTH-1:0]       gain_addr;
    logic [GAIN_WIDTH-1:0]      gain_wdata;
    logic                       overrun_clr;
    logic signed [15:0]         data_out;
    logic                       valid_out;
    logic                       busy;
    logic                       overrun;

    modport master (
        output band_data, band_valid, gain_we, gain_addr, gain_wdata, overrun_clr,
        input  data_out, valid_out, busy, overrun
    );

    modport slave (
        input  band_data, band_valid, gain_we, gain_addr, gain_wdata, overrun_clr,
        output data_out, valid_out, busy, overrun
    );
endinterface

// File: rtl/band_mixer.sv
// Serial gain-weighted mixer: one MAC per band per cycle, then scale by unity
// gain with floor rounding and saturate to 16 bits.
module band_mixer #(
    parameter int NUM_BANDS  = 16,
    parameter int GAIN_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_BANDS)
) (
    input  logic          clk,
    input  logic          rst,
    band_mixer_if.slave   bus
);
    localparam int ACC_W  = 16 + GAIN_WIDTH + 1 + IDX_WIDTH;
    localparam int PROD_W = 16 + GAIN_WIDTH + 1;
    localparam int SH     = GAIN_WIDTH - 1;
    localparam logic [GAIN_WIDTH-1:0]   UNITY   = GAIN_WIDTH'(1 << (GAIN_WIDTH - 1));
    localparam logic [IDX_WIDTH-1:0]    LAST    = IDX_WIDTH'(NUM_BANDS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(32768));

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

    state_e                          state_q, state_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [IDX_WIDTH-1:0]            idx_q, idx_d;
    logic [NUM_BANDS-1:0][15:0]      samp_q, samp_d;
    logic [NUM_BANDS-1:0][GAIN_WIDTH-1:0] gain_q, gain_d;
    logic signed [15:0]              dout_q, dout_d;
    logic                            vout_q, vout_d;
    logic                            ovr_q, ovr_d;

    logic signed [15:0]              s_cur;
    logic signed [GAIN_WIDTH:0]      g_cur;
    logic signed [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]         shifted;

    // Gain is zero-extended so 255 stays positive in the signed multiply.
    assign s_cur   = $signed(samp_q[idx_q]);
    assign g_cur   = $signed({1'b0, gain_q[idx_q]});
    assign prod    = PROD_W'(s_cur) * PROD_W'(g_cur);
    assign shifted = acc_q >>> SH;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        samp_d  = samp_q;
        gain_d  = gain_q;
        dout_d  = dout_q;
        vout_d  = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: if (bus.band_valid) begin
                samp_d  = bus.band_data;
                acc_d   = '0;
                idx_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) state_d = OUTPUT;
            end
            OUTPUT: begin
                if (shifted > SAT_MAX)      dout_d = 16'sh7fff;
                else if (shifted < SAT_MIN) dout_d = -16'sh8000;
                else                        dout_d = shifted[15:0];
                vout_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new overrun event wins over a simultaneous clear.
        if (bus.overrun_clr) ovr_d = 1'b0;
        if (bus.band_valid && state_q != IDLE) ovr_d = 1'b1;
        if (bus.gain_we && ({1'b0, bus.gain_addr} < (IDX_WIDTH+1)'(NUM_BANDS)))
            gain_d[bus.gain_addr] = bus.gain_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            samp_q  <= '0;
            gain_q  <= {NUM_BANDS{UNITY}};
            dout_q  <= '0;
            vout_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            samp_q  <= samp_d;
            gain_q  <= gain_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.valid_out = vout_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: fixed vectors, directed corner sequences
// and randomized samples against an arithmetic reference model.
module tb_band_mixer;
    localparam int NB = 16;
    localparam int GW = 8;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    band_mixer_if #(.NUM_BANDS(NB), .GAIN_WIDTH(GW), .IDX_WIDTH(IW)) bus ();
    band_mixer #(.NUM_BANDS(NB), .GAIN_WIDTH(GW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int m_gain[NB];
    int bands[NB];

    typedef struct {
        int     bval;
        int     sidx;
        int     sval;
        int     gall;
        int     gs;
        longint exp;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Mixed output = floor(sum(sample*gain) / 128), clamped to int16.
    function automatic longint ref_mix();
        longint sum = 0;
        longint r;
        for (int k = 0; k < NB; k++) sum += longint'(bands[k]) * longint'(m_gain[k]);
        r = sum >>> (GW - 1);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic drive_bands();
        for (int k = 0; k < NB; k++) bus.band_data[k] = 16'(bands[k]);
    endtask

    task automatic rand_bands();
        for (int k = 0; k < NB; k++) bands[k] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic set_gain(input int a, input int v);
        @(negedge clk);
        bus.gain_we = 1'b1; bus.gain_addr = IW'(a); bus.gain_wdata = GW'(v);
        @(negedge clk);
        bus.gain_we = 1'b0;
        m_gain[a] = v;
    endtask

    task automatic run_one(input string nm, input longint exp);
        int  n = 0;
        bit  got = 1'b0;
        logic signed [15:0] d;
        @(negedge clk);
        drive_bands();
        bus.band_valid = 1'b1;
        @(negedge clk);
        bus.band_valid = 1'b0;
        for (int k = 0; k < NB; k++) bus.band_data[k] = 16'($urandom);
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (bus.valid_out) got = 1'b1;
        end
        chk({nm, " latency"}, got ? n : -1, 17);
        chk({nm, " data"}, bus.data_out, exp);
        d = bus.data_out;
        @(negedge clk);
        chk({nm, " pulse width"}, bus.valid_out, 0);
        chk({nm, " hold"}, bus.data_out, d);
    endtask

    vec_t vecs[$];
    longint expq[$];

    initial begin
        int pulses;
        longint got_d, expa;

        bus.band_valid = 0; bus.gain_we = 0; bus.gain_addr = '0; bus.gain_wdata = '0;
        bus.overrun_clr = 0; bus.band_data = '0;
        for (int k = 0; k < NB; k++) m_gain[k] = 128;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset data_out", bus.data_out, 0);
        chk("reset valid_out", bus.valid_out, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset overrun", bus.overrun, 0);
        rst = 1'b0;

        // Reset gains are unity: no writes before the first sample.
        for (int k = 0; k < NB; k++) bands[k] = 100;
        run_one("unity after reset", 1600);

        vecs = '{
            '{100,    -1, 0,  128, 0,  1600},
            '{32767,  -1, 0,  255, 0,  32767},
            '{-32768, -1, 0,  255, 0,  -32768},
            '{1000,    3, -3, 0,   64, -2},
            '{-1,     -1, 0,  128, 0,  -16},
            '{2048,   -1, 0,  128, 0,  32767},
            '{2047,   -1, 0,  128, 0,  32752},
            '{-2048,  -1, 0,  128, 0,  -32768},
            '{-1,     -1, 0,  1,   0,  -1},
            '{1,      -1, 0,  1,   0,  0},
            '{0,      -1, 0,  200, 0,  0}
        };
        foreach (vecs[i]) begin
            for (int k = 0; k < NB; k++) set_gain(k, vecs[i].gall);
            for (int k = 0; k < NB; k++) bands[k] = vecs[i].bval;
            if (vecs[i].sidx >= 0) begin
                set_gain(vecs[i].sidx, vecs[i].gs);
                bands[vecs[i].sidx] = vecs[i].sval;
            end
            run_one($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Overrun: second band_valid 5 cycles in is ignored.
        for (int k = 0; k < NB; k++) set_gain(k, 128);
        rand_bands();
        expa = ref_mix();
        pulses = 0; got_d = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.valid_out) begin pulses++; got_d = bus.data_out; end
            bus.band_valid = (c == 0 || c == 5);
            if (c == 0) drive_bands();
            if (c == 5) for (int k = 0; k < NB; k++) bus.band_data[k] = 16'($urandom);
        end
        chk("overrun pulses", pulses, 1);
        chk("overrun data", got_d, expa);
        chk("overrun set", bus.overrun, 1);
        @(negedge clk); bus.overrun_clr = 1'b1;
        @(negedge clk); bus.overrun_clr = 1'b0;
        chk("overrun clr", bus.overrun, 0);

        // Clear coinciding with a new overrun event leaves the flag set.
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.valid_out) pulses++;
            if (c == 5) chk("overrun clr vs event", bus.overrun, 1);
            bus.band_valid  = (c == 0 || c == 4);
            bus.overrun_clr = (c == 4);
            if (c == 0) drive_bands();
        end
        chk("clr vs event pulses", pulses, 1);
        @(negedge clk); bus.overrun_clr = 1'b1;
        @(negedge clk); bus.overrun_clr = 1'b0;

        // Gain writes during ACCUM: same-edge read of band 5 sees the old gain,
        // band 9 is rewritten before it is read.
        for (int k = 0; k < NB; k++) bands[k] = 100;
        pulses = 0; got_d = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.valid_out) begin pulses++; got_d = bus.data_out; end
            bus.band_valid = (c == 0);
            if (c == 0) drive_bands();
            bus.gain_we    = (c == 6 || c == 9);
            bus.gain_addr  = (c == 6) ? IW'(5) : IW'(9);
            bus.gain_wdata = '0;
        end
        bus.gain_we = 1'b0;
        m_gain[5] = 0; m_gain[9] = 0;
        chk("gain write in accum pulses", pulses, 1);
        chk("gain write in accum data", got_d, 1500);

        // Reset mid-ACCUM aborts and restores unity gains.
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.valid_out) pulses++;
            bus.band_valid = (c == 0);
            if (c == 0) drive_bands();
            rst = (c == 8);
        end
        for (int k = 0; k < NB; k++) m_gain[k] = 128;
        chk("abort pulses", pulses, 0);
        chk("abort data_out", bus.data_out, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort overrun", bus.overrun, 0);
        run_one("unity after abort", 1600);

        // Random samples with random gains.
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 3; j++) set_gain(int'($urandom_range(0, NB-1)), int'($urandom_range(0, 255)));
            rand_bands();
            run_one($sformatf("rand%0d", i), ref_mix());
        end

        // Back-to-back at the 18-cycle throughput limit.
        for (int k = 0; k < NB; k++) set_gain(k, int'($urandom_range(0, 255)));
        pulses = 0;
        for (int c = 0; c < 10*18 + 6; c++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                pulses++;
                if (expq.size() > 0) chk($sformatf("b2b%0d", pulses), bus.data_out, expq.pop_front());
                else chk("b2b unexpected pulse", 1, 0);
            end
            if (c % 18 == 0 && c / 18 < 10) begin
                rand_bands();
                expq.push_back(ref_mix());
                drive_bands();
                bus.band_valid = 1'b1;
            end else begin
                bus.band_valid = 1'b0;
            end
        end
        chk("b2b pulses", pulses, 10);
        chk("b2b overrun", bus.overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/band_mixer.md
BAND_MIXER -- requirements
Module: band_mixer

Interface
REQ-001 Parameter NUM_BANDS, default 16, number of band sample inputs mixed per output sample.
REQ-002 Parameter GAIN_WIDTH, default 8, unsigned per-band gain width; unity gain = 2^(GAIN_WIDTH-1) = 128.
REQ-003 Parameter IDX_WIDTH, default $clog2(NUM_BANDS), band index / gain address width.
REQ-004 clk  input  1  system clock (4.4 MHz).
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 band_data  input  NUM_BANDS x 16, signed  one sample per band from the band playback modules; band k at bits [16k+15:16k].
REQ-007 band_valid  input  1  single-cycle strobe; all band_data lanes valid together.
REQ-008 gain_we  input  1  gain register write enable.
REQ-009 gain_addr  input  IDX_WIDTH  band index of gain write.
REQ-010 gain_wdata  input  GAIN_WIDTH  unsigned gain value.
REQ-011 overrun_clr  input  1  clears overrun flag.
REQ-012 data_out  output  16, signed  mixed, scaled, saturated sample.
REQ-013 valid_out  output  1  single-cycle strobe marking new data_out.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 overrun  output  1  sticky: band_valid arrived while busy.

Function
REQ-016 FSM states IDLE, ACCUM, OUTPUT; encoding free.
REQ-017 IDLE + band_valid: capture all band_data lanes into sample registers, clear accumulator, idx <= 0, go ACCUM.
REQ-018 ACCUM, each edge: acc <= acc + sample[idx] * signed(zero-extended gain[idx]); idx <= idx+1; after the edge adding idx = NUM_BANDS-1, go OUTPUT.
REQ-019 Accumulator width = 16 + GAIN_WIDTH + 1 + IDX_WIDTH bits signed (29 at defaults); no intermediate overflow possible.
REQ-020 OUTPUT, single edge: data_out <= saturate16(acc >>> (GAIN_WIDTH-1)), arithmetic shift (floor toward -inf); valid_out <= 1; go IDLE.
REQ-021 Saturation: result > 32767 -> 32767; result < -32768 -> -32768.
REQ-022 Latency: valid_out high in the cycle following the (NUM_BANDS+1)-th edge after the edge sampling band_valid (17 at defaults); high exactly one cycle.
REQ-023 data_out holds its value between valid_out strobes.
REQ-024 band_valid in ACCUM or OUTPUT: ignored (samples not recaptured, computation undisturbed); overrun <= 1.
REQ-025 band_valid is accepted in the IDLE cycle immediately following OUTPUT (back-to-back throughput = NUM_BANDS+2 cycles per sample).
REQ-026 overrun_clr clears overrun; simultaneous overrun_clr and new overrun event -> overrun = 1.
REQ-027 Gain write: gain[gain_addr] <= gain_wdata at the edge; writes allowed in any state; an ACCUM read of the same index at that edge uses the old value.
REQ-028 gain_addr >= NUM_BANDS: write ignored.
REQ-029 band_data is sampled only on the accepted band_valid edge; changes afterwards do not affect the result.

Reset
REQ-030 rst asserted: state IDLE, acc 0, idx 0, all sample registers 0, data_out 0, valid_out 0, busy 0, overrun 0, every gain = 128 (unity).
REQ-031 rst mid-ACCUM/OUTPUT aborts the computation; no valid_out is produced for the aborted sample.
REQ-032 First band_valid after rst deassertion is accepted normally.

Verification
REQ-033 Default gains, all 16 bands = 100, band_valid pulse -> valid_out one cycle, 17 edges later, data_out = 1600.
REQ-034 All gains 255 and all bands 32767 -> data_out = 32767; all bands -32768 -> data_out = -32768.
REQ-035 Gains 0 except band 3 = 64; band 3 = -3, others 1000 -> data_out = -2 (floor of -1.5).
REQ-036 Second band_valid 5 cycles after first -> single valid_out, result from first sample set, overrun = 1; overrun_clr pulse -> overrun = 0.
REQ-037 rst pulsed 8 cycles into ACCUM -> no valid_out; data_out = 0; busy = 0; gains read back as unity in a subsequent 100-per-band test (output 1600).
REQ-038 Back-to-back band_valid every 18 cycles for 10 samples -> 10 valid_out pulses, overrun stays 0.
